// File: rtl/aes_key_load_arb.sv
// rtl/aes_key_load_arb.sv - round-robin arbiter streaming one key-share load at a time into the AES core
module aes_key_load_arb #(
  parameter int NumReq        = 2,
  parameter int NumWords      = 8,
  parameter int SettleCycles  = 4,
  parameter int TimeoutCycles = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        core_idle_i,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq-1:0]           wvalid_i,
  input  logic [NumReq*32-1:0]        ks0_i,
  input  logic [NumReq*32-1:0]        ks1_i,
  output logic [NumReq-1:0]           wready_o,
  output logic [NumReq-1:0]           gnt_o,
  output logic [NumReq-1:0]           done_o,
  output logic [NumReq-1:0]           err_o,
  output logic [$clog2(NumWords)-1:0] key_idx_o,
  output logic [31:0]                 key_ks0_o,
  output logic [31:0]                 key_ks1_o,
  output logic                        key_qe_o,
  output logic                        busy_o
);

  localparam int IdxW = $clog2(NumWords);
  localparam int RrW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int ToW  = $clog2(TimeoutCycles);
  localparam int SeW  = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_e;

  state_e            state_q, state_d;
  logic [NumReq-1:0] gnt_q, done_q, err_q, pick;
  logic [RrW-1:0]    rr_q, gidx, pick_idx, cand;
  logic              pick_vld;
  logic [IdxW-1:0]   wcnt_q, key_idx_q;
  logic [ToW-1:0]    tcnt_q;
  logic [SeW-1:0]    scnt_q;
  logic [31:0]       ks0_q, ks1_q;
  logic              key_qe_q;
  logic              grant, accept, owner_req, last_word, timeout, abort, settle_end;

  // Round-robin pick: first requester at or after rr_q, wrapping around
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = RrW'((int'(rr_q) + i) % NumReq);
      if (!pick_vld && req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
    pick = pick_vld ? (NumReq'(1) << pick_idx) : '0;
  end

  // Binary index of the current owner, used to select its data slice
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_q[i]) gidx = RrW'(i);
    end
  end

  assign grant      = (state_q == IDLE) && core_idle_i && pick_vld;
  assign accept     = (state_q == LOAD) && |(wvalid_i & gnt_q);
  assign owner_req  = |(req_i & gnt_q);
  assign last_word  = (wcnt_q == IdxW'(NumWords - 1));
  assign timeout    = (tcnt_q == ToW'(TimeoutCycles - 2));
  assign abort      = (state_q == LOAD) && (!owner_req || (!accept && timeout));
  assign settle_end = (scnt_q == SeW'(SettleCycles - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; a withdrawn request or stall aborts before a final accept can settle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = LOAD;
      LOAD: begin
        if (abort)                    state_d = IDLE;
        else if (accept && last_word) state_d = SETTLE;
      end
      SETTLE:  if (settle_end) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: only the owner sees wready, and only while words are flowing
  always_comb begin
    wready_o = (state_q == LOAD) ? gnt_q : '0;
    busy_o   = (state_q != IDLE);
  end

  // Grant, counters, key-port registers and completion pulses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rr_q      <= '0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      key_idx_q <= '0;
      ks0_q     <= '0;
      ks1_q     <= '0;
      key_qe_q  <= 1'b0;
    end else begin
      key_qe_q <= accept;
      done_q   <= '0;
      err_q    <= '0;
      if (accept) begin
        key_idx_q <= wcnt_q;
        ks0_q     <= ks0_i[{gidx, 5'b0} +: 32];
        ks1_q     <= ks1_i[{gidx, 5'b0} +: 32];
        wcnt_q    <= wcnt_q + IdxW'(1);
      end
      case (state_q)
        IDLE: begin
          if (grant) begin
            gnt_q  <= pick;
            wcnt_q <= '0;
            tcnt_q <= '0;
          end
        end
        LOAD: begin
          tcnt_q <= accept ? '0 : tcnt_q + ToW'(1);
          scnt_q <= '0;
          if (abort) begin
            err_q <= gnt_q;
            gnt_q <= '0;
          end
        end
        SETTLE: begin
          if (settle_end) begin
            done_q <= gnt_q;
            gnt_q  <= '0;
            rr_q   <= (gidx == RrW'(NumReq - 1)) ? '0 : gidx + RrW'(1);
          end else begin
            scnt_q <= scnt_q + SeW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign key_idx_o = key_idx_q;
  assign key_ks0_o = ks0_q;
  assign key_ks1_o = ks1_q;
  assign key_qe_o  = key_qe_q;

endmodule

// File: tb/tb_aes_key_load_arb.sv
// tb/tb_aes_key_load_arb.sv - randomized self-checking bench for aes_key_load_arb
module tb_aes_key_load_arb;
  localparam int NR = 2;
  localparam int NW = 8;
  localparam int SC = 4;
  localparam int TC = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_idle = 1'b1;
  logic [NR-1:0] req = '0, wvalid = '0;
  logic [NR*32-1:0] ks0 = '0, ks1 = '0;
  logic [NR-1:0] wready_o, gnt_o, done_o, err_o;
  logic [2:0] key_idx_o;
  logic [31:0] key_ks0_o, key_ks1_o;
  logic key_qe_o, busy_o;

  aes_key_load_arb #(.NumReq(NR), .NumWords(NW), .SettleCycles(SC), .TimeoutCycles(TC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_idle_i(core_idle), .req_i(req), .wvalid_i(wvalid),
    .ks0_i(ks0), .ks1_i(ks1), .wready_o(wready_o), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .key_idx_o(key_idx_o), .key_ks0_o(key_ks0_o), .key_ks1_o(key_ks1_o),
    .key_qe_o(key_qe_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;
  logic [31:0] mem0 [NR][NW];
  logic [31:0] mem1 [NR][NW];
  int sent [NR];
  int limit [NR];
  logic [NR-1:0] wv_en = '0, rereq = '0, acc_prev = '0, prev_gnt = '0;
  bit gaps = 0;
  bit pend = 0;
  logic [2:0] pend_idx;
  logic [31:0] pend_ks0, pend_ks1;
  int load_idx = 0;
  logic [NR-1:0] gnt_hist[$], done_hist[$], err_hist[$];
  int gnt_cyc, done_cyc, err_cyc, last_qe_cyc, first_qe_cyc, qe_cnt, first_qe_idx;

  // Requester model plus key-port scoreboard, advanced one clock per call
  task automatic step();
    int w;
    @(negedge clk);
    cyc++;
    n_checks++;
    if (pend) begin
      if (key_qe_o !== 1'b1 || key_idx_o !== pend_idx || key_ks0_o !== pend_ks0 || key_ks1_o !== pend_ks1)
        $display("FAIL qe_word cyc=%0d: got qe=%b idx=%0d ks0=%h ks1=%h, want qe=1 idx=%0d ks0=%h ks1=%h",
                 cyc, key_qe_o, key_idx_o, key_ks0_o, key_ks1_o, pend_idx, pend_ks0, pend_ks1);
      else n_pass++;
      if (qe_cnt == 0) begin first_qe_cyc = cyc; first_qe_idx = int'(key_idx_o); end
      qe_cnt++;
      last_qe_cyc = cyc;
    end else begin
      if (key_qe_o !== 1'b0) $display("FAIL qe_spurious cyc=%0d: got %b want 0", cyc, key_qe_o);
      else n_pass++;
    end
    pend = 0;
    n_checks++;
    if (!$onehot0(gnt_o) || (wready_o & ~gnt_o) != '0 || (done_o & err_o) != '0)
      $display("FAIL grant_sanity cyc=%0d: gnt=%b wready=%b done=%b err=%b, want one-hot gnt covering wready, no done+err",
               cyc, gnt_o, wready_o, done_o, err_o);
    else n_pass++;
    if (gnt_o != '0 && prev_gnt == '0) begin
      gnt_hist.push_back(gnt_o);
      gnt_cyc = cyc;
      load_idx = 0;
    end
    prev_gnt = gnt_o;
    if (done_o != '0) begin done_hist.push_back(done_o); done_cyc = cyc; end
    if (err_o != '0) begin err_hist.push_back(err_o); err_cyc = cyc; end
    for (int r = 0; r < NR; r++) begin
      sent[r] += int'(acc_prev[r]);
      if (done_o[r] || err_o[r]) begin
        sent[r] = 0;
        if (rereq[r]) rereq[r] = 1'b0;
        else req[r] = 1'b0;
      end
      w = (sent[r] < NW) ? sent[r] : NW - 1;
      wvalid[r] = wv_en[r] && (sent[r] < limit[r]) && (!gaps || $urandom_range(0, 3) != 0);
      ks0[32*r +: 32] = mem0[r][w];
      ks1[32*r +: 32] = mem1[r][w];
      acc_prev[r] = wready_o[r] & wvalid[r];
      if (acc_prev[r]) begin
        pend = 1;
        pend_idx = 3'(load_idx);
        pend_ks0 = mem0[r][w];
        pend_ks1 = mem1[r][w];
        load_idx++;
      end
    end
  endtask

  task automatic wait_events(input int n, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_hist.size() + err_hist.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic clear_hist();
    gnt_hist.delete(); done_hist.delete(); err_hist.delete();
    qe_cnt = 0; gnt_cyc = -1; done_cyc = -1; err_cyc = -1;
    last_qe_cyc = -1; first_qe_cyc = -1; first_qe_idx = -1;
  endtask

  task automatic clear_model();
    pend = 0; acc_prev = '0; load_idx = 0; prev_gnt = '0; rereq = '0;
    for (int r = 0; r < NR; r++) begin sent[r] = 0; limit[r] = NW; end
  endtask

  task automatic fill_random(input int r);
    for (int w = 0; w < NW; w++) begin mem0[r][w] = $urandom; mem1[r][w] = $urandom; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; wvalid = '0; wv_en = '0; core_idle = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (gnt_o !== '0) $display("FAIL rst_gnt: got %b want 0", gnt_o); else n_pass++;
    n_checks++; if (done_o !== '0 || err_o !== '0) $display("FAIL rst_done_err: got %b/%b want 0/0", done_o, err_o); else n_pass++;
    n_checks++; if (key_qe_o !== 1'b0) $display("FAIL rst_qe: got %b want 0", key_qe_o); else n_pass++;
    n_checks++; if (key_idx_o !== 3'd0) $display("FAIL rst_idx: got %0d want 0", key_idx_o); else n_pass++;
    n_checks++; if (key_ks0_o !== 32'd0 || key_ks1_o !== 32'd0) $display("FAIL rst_data: got %h/%h want 0/0", key_ks0_o, key_ks1_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0 || wready_o !== '0) $display("FAIL rst_busy_wready: got %b/%b want 0/0", busy_o, wready_o); else n_pass++;
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    clear_hist();
    for (int w = 0; w < NW; w++) begin mem0[0][w] = 32'hFFFF_FFFC + 32'(w); mem1[0][w] = 32'(w); end
    gaps = 0; wv_en = 2'b01; req = 2'b01;
    wait_events(1, 100, ok);
    n_checks++; if (!ok) $display("FAIL single_timeout: no done/err within 100 cycles, want done"); else n_pass++;
    n_checks++; if (gnt_hist.size() != 1 || gnt_hist[0] !== 2'b01) $display("FAIL single_gnt: got %0d grants first=%b want 1 grant 01", gnt_hist.size(), gnt_hist[0]); else n_pass++;
    n_checks++; if (qe_cnt != NW || last_qe_cyc - first_qe_cyc != NW - 1) $display("FAIL single_qe_run: got %0d strobes over %0d cycles want %0d consecutive", qe_cnt, last_qe_cyc - first_qe_cyc + 1, NW); else n_pass++;
    n_checks++; if (done_hist.size() != 1 || done_hist[0] !== 2'b01 || err_hist.size() != 0) $display("FAIL single_done: got done=%0d err=%0d want one done 01", done_hist.size(), err_hist.size()); else n_pass++;
    n_checks++; if (done_cyc - last_qe_cyc != SC) $display("FAIL single_settle: got done %0d cycles after last qe want %0d", done_cyc - last_qe_cyc, SC); else n_pass++;
    n_checks++; if (done_cyc - gnt_cyc + 2 != 1 + NW + SC + 1) $display("FAIL single_latency: got %0d cycles grant decision to done want %0d", done_cyc - gnt_cyc + 2, 1 + NW + SC + 1); else n_pass++;
    step();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy_o); else n_pass++;
    wv_en = '0;
  endtask

  task automatic test_contention();
    bit ok;
    test_reset();
    clear_hist();
    fill_random(0); fill_random(1);
    gaps = 1; wv_en = 2'b11; req = 2'b11;
    wait_events(2, 400, ok);
    n_checks++; if (!ok) $display("FAIL cont_timeout: got %0d completions want 2", done_hist.size() + err_hist.size()); else n_pass++;
    n_checks++; if (gnt_hist.size() != 2 || gnt_hist[0] !== 2'b01 || gnt_hist[1] !== 2'b10) $display("FAIL cont_order: got %0d grants %b,%b want 01,10", gnt_hist.size(), gnt_hist[0], gnt_hist[1]); else n_pass++;
    n_checks++; if (done_hist.size() != 2 || done_hist[0] !== 2'b01 || done_hist[1] !== 2'b10 || err_hist.size() != 0) $display("FAIL cont_done: got %0d dones %0d errs want 01,10 and no err", done_hist.size(), err_hist.size()); else n_pass++;
    n_checks++; if (qe_cnt != 2 * NW) $display("FAIL cont_words: got %0d strobes want %0d", qe_cnt, 2 * NW); else n_pass++;
  endtask

  task automatic test_fairness();
    bit ok;
    clear_hist();
    fill_random(0); fill_random(1);
    gaps = 1; wv_en = 2'b11; req = 2'b11; rereq = 2'b01;
    wait_events(3, 600, ok);
    n_checks++; if (!ok) $display("FAIL fair_timeout: got %0d completions want 3", done_hist.size() + err_hist.size()); else n_pass++;
    n_checks++; if (gnt_hist.size() != 3 || gnt_hist[0] !== 2'b01 || gnt_hist[1] !== 2'b10 || gnt_hist[2] !== 2'b01) $display("FAIL fair_order: got %0d grants %b,%b,%b want 01,10,01", gnt_hist.size(), gnt_hist[0], gnt_hist[1], gnt_hist[2]); else n_pass++;
    wv_en = '0;
  endtask

  task automatic test_timeout();
    bit ok;
    clear_hist();
    fill_random(1);
    gaps = 0; limit[1] = 3; wv_en = 2'b10; req = 2'b10;
    wait_events(1, 200, ok);
    n_checks++; if (!ok) $display("FAIL to_wait: no err within 200 cycles, want err"); else n_pass++;
    n_checks++; if (err_hist.size() != 1 || err_hist[0] !== 2'b10 || done_hist.size() != 0) $display("FAIL to_err: got %0d errs %0d dones want one err 10", err_hist.size(), done_hist.size()); else n_pass++;
    n_checks++; if (qe_cnt != 3) $display("FAIL to_words: got %0d strobes want 3", qe_cnt); else n_pass++;
    n_checks++; if (err_cyc - last_qe_cyc != TC - 1) $display("FAIL to_latency: got err %0d cycles after last qe want %0d", err_cyc - last_qe_cyc, TC - 1); else n_pass++;
    step();
    n_checks++; if (busy_o !== 1'b0 || gnt_o !== '0) $display("FAIL to_idle: got busy=%b gnt=%b want 0/0", busy_o, gnt_o); else n_pass++;
    limit[1] = NW; wv_en = '0;
  endtask

  task automatic test_block_withdraw();
    bit ok;
    int idle_cyc, drop_cyc;
    clear_hist();
    fill_random(0);
    gaps = 0; core_idle = 1'b0; wv_en = 2'b01; req = 2'b01;
    repeat (20) step();
    n_checks++; if (gnt_hist.size() != 0 || busy_o !== 1'b0) $display("FAIL blk_nogrant: got %0d grants busy=%b want 0/0", gnt_hist.size(), busy_o); else n_pass++;
    core_idle = 1'b1; idle_cyc = cyc;
    step();
    n_checks++; if (gnt_hist.size() != 1 || gnt_hist[0] !== 2'b01 || gnt_cyc != idle_cyc + 1) $display("FAIL blk_grant: got %0d grants at +%0d want 01 at +1", gnt_hist.size(), gnt_cyc - idle_cyc); else n_pass++;
    for (int i = 0; i < 20 && qe_cnt < 2; i++) step();
    req = 2'b00; wv_en = '0; drop_cyc = cyc;
    wait_events(1, 20, ok);
    n_checks++; if (!ok || err_hist.size() != 1 || err_hist[0] !== 2'b01 || done_hist.size() != 0) $display("FAIL wd_err: got %0d errs %0d dones want one err 01", err_hist.size(), done_hist.size()); else n_pass++;
    n_checks++; if (err_cyc != drop_cyc + 1) $display("FAIL wd_latency: got err %0d cycles after drop want 1", err_cyc - drop_cyc); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    clear_hist();
    fill_random(0);
    gaps = 0; wv_en = 2'b01; req = 2'b01;
    for (int i = 0; i < 40 && qe_cnt < 5; i++) step();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (gnt_o !== '0 || key_qe_o !== 1'b0 || busy_o !== 1'b0 || wready_o !== '0) $display("FAIL rmid_ctrl: got gnt=%b qe=%b busy=%b wready=%b want all 0", gnt_o, key_qe_o, busy_o, wready_o); else n_pass++;
    n_checks++; if (key_idx_o !== 3'd0 || key_ks0_o !== 32'd0 || key_ks1_o !== 32'd0 || done_o !== '0 || err_o !== '0) $display("FAIL rmid_data: got idx=%0d ks0=%h ks1=%h done=%b err=%b want all 0", key_idx_o, key_ks0_o, key_ks1_o, done_o, err_o); else n_pass++;
    clear_model();
    clear_hist();
    @(negedge clk);
    rst_n = 1'b1;
    wait_events(1, 100, ok);
    n_checks++; if (!ok || done_hist.size() != 1 || done_hist[0] !== 2'b01 || err_hist.size() != 0) $display("FAIL rmid_reload: got %0d dones %0d errs want one done 01", done_hist.size(), err_hist.size()); else n_pass++;
    n_checks++; if (first_qe_idx != 0 || qe_cnt != NW) $display("FAIL rmid_restart: got first idx %0d and %0d strobes want 0 and %0d", first_qe_idx, qe_cnt, NW); else n_pass++;
    wv_en = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    clear_hist();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_block_withdraw();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
